mic_pack_fifo: RTL and testbench
================================

MIC_PACK_FIFO -- requirements
Module: mic_pack_fifo

Interface
REQ-001 Parameter WIDTH, default 8, bits per packed sample word (2..32).
REQ-002 Parameter DEPTH, default 16, word storage depth; power of two, 4..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, level at which almost_full asserts.
REQ-004 Parameter MSB_FIRST, default 1; 1 means the first received bit lands in dout[WIDTH-1], 0 means it lands in dout[0].
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 micData  in  1  serial microphone bit, sampled when wr=1.
REQ-008 wr  in  1  bit-sample enable, one bit accepted per clk cycle while high.
REQ-009 rd  in  1  word pop request, one word per clk cycle while high.
REQ-010 clr_flags  in  1  clears the sticky overflow and underflow flags.
REQ-011 dout  out  WIDTH  registered popped word.
REQ-012 dout_valid  out  1  one-cycle pulse, dout updated this cycle.
REQ-013 empty  out  1  level==0.
REQ-014 full  out  1  level==DEPTH.
REQ-015 almost_full  out  1  level>=AF_LEVEL.
REQ-016 level  out  clog2(DEPTH)+1  stored word count.
REQ-017 overflow  out  1  sticky, word dropped because the FIFO was full.
REQ-018 underflow  out  1  sticky, rd seen while the FIFO was empty.

Function
REQ-019 Packer: each cycle with wr=1 SHALL shift micData into a WIDTH-bit shift register and increment bit_cnt; wr=0 holds both unchanged.
REQ-020 When the WIDTH-th bit is accepted, the packer SHALL issue an internal push that same cycle and reset bit_cnt to 0; no bit is lost across word boundaries.
REQ-021 A push SHALL write at wr_ptr and advance wr_ptr modulo DEPTH; the word is visible to rd on the next cycle.
REQ-022 rd=1 with empty=0 SHALL read mem[rd_ptr] into dout, advance rd_ptr modulo DEPTH, and pulse dout_valid the following cycle (read latency 1).
REQ-023 rd=1 with empty=1 SHALL leave dout, the pointers and level unchanged, set underflow, and not pulse dout_valid.
REQ-024 A push with full=1 and no simultaneous valid pop SHALL drop the word and set overflow; storage and level are unchanged.
REQ-025 A push and a pop in the same cycle with full=1 SHALL both succeed, leaving level unchanged.
REQ-026 A push and a pop in the same cycle with 0<level<DEPTH SHALL both succeed, leaving level unchanged.
REQ-027 Level update: +1 on push only, -1 on pop only, unchanged otherwise; empty, full and almost_full derive combinationally from level.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-029 clr_flags=1 SHALL clear overflow and underflow next cycle; a set event in the same cycle as clr_flags wins (flag stays 1).

Reset
REQ-030 reset=1 at a clk edge SHALL zero wr_ptr, rd_ptr, level, bit_cnt, the shift register, dout, dout_valid, overflow and underflow; empty=1, full=0, almost_full=0.
REQ-031 Reset mid-word SHALL discard the partial word; reset mid-operation SHALL discard stored words (memory contents need not be cleared).
REQ-032 Inputs during reset SHALL be ignored; normal operation starts on the first edge with reset=0.

Structure
REQ-033 Shared package mic_pkg SHALL hold default WIDTH/DEPTH constants and the clog2-based level width function.
REQ-034 The packer SHALL be a sub-module mic_bit_packer (shift register, bit_cnt, word_done pulse); storage and control stay in mic_pack_fifo.
REQ-035 Storage SHALL be an inferable synchronous-read RAM, DEPTH x WIDTH.

Verification
REQ-036 Reset, then WIDTH=8, MSB_FIRST=1, hold wr for 8 cycles with bits 1,0,1,0,1,1,0,0 -> level=1 next cycle; rd -> dout=8'hAC with dout_valid one cycle later.
REQ-037 MSB_FIRST=0, same bits -> dout=8'h35.
REQ-038 DEPTH=16, push 16 words -> full=1, almost_full asserted at level 14; 17th word -> overflow=1, level=16; pop all -> original 16 words in order, then empty=1.
REQ-039 Full FIFO, word_done and rd in the same cycle -> level stays 16, overflow stays 0, next-popped word correct.
REQ-040 Empty FIFO, rd=1 -> underflow=1, no dout_valid; clr_flags -> underflow=0.
REQ-041 Reset asserted after 5 of 8 bits, then 8 new bits -> exactly one word equal to the new 8 bits; 40 push/pop cycles -> pointer wrap, with order preserved.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared defaults and sizing helpers for the microphone bit-packing FIFO.
package mic_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  // Level must represent 0..depth inclusive, hence one extra bit.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mic_bit_packer.sv
// Serial-to-parallel packer: collects WIDTH microphone bits, flags word_done on the last bit.
module mic_bit_packer
  import mic_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    word_done_o = 1'b0;
    if (wr_i) begin
      if (MSB_FIRST) begin
        shift_d = {shift_q[WIDTH-2:0], bit_i};
      end else begin
        shift_d = {bit_i, shift_q[WIDTH-1:1]};
      end
      if (cnt_q == LastCnt) begin
        cnt_d       = '0;
        word_done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Completed word includes the bit accepted this cycle so it can be pushed immediately.
  assign word_o = shift_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mic_pack_fifo.sv
// Microphone bit packer feeding a DEPTH x WIDTH synchronous-read FIFO with sticky error flags.
module mic_pack_fifo
  import mic_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AF_LEVEL  = DEPTH - 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          micData,
  input  logic                          wr,
  input  logic                          rd,
  input  logic                          clr_flags,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] AfLvl   = LvlW'(AF_LEVEL);

  logic [WIDTH-1:0] pack_word;
  logic             word_done;

  mic_bit_packer #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .wr_i       (wr),
    .bit_i      (micData),
    .word_o     (pack_word),
    .word_done_o(word_done)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             pop, push_ok;

  assign empty       = (level_q == '0);
  assign full        = (level_q == FullLvl);
  assign almost_full = (level_q >= AfLvl);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop     = rd & ~empty;
  assign push_ok = word_done & (~full | pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = (word_done & full & ~pop) | (overflow_q & ~clr_flags);
    underflow_d = (rd & empty) | (underflow_q & ~clr_flags);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= pack_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_valid_q <= pop;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      if (pop) dout_q <= mem_q[rd_ptr_q];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_mic_pack_fifo.sv
// Scoreboard bench: MSB-first and LSB-first instances share one bit stream.
module tb_mic_pack_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic micData = 1'b0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic clr_flags = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, empty_a, empty_b, full_a, full_b, af_a, af_b;
  logic [4:0] level_a, level_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] ea, eb;

  always #5 clk = ~clk;

  mic_pack_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .micData(micData), .wr(wr), .rd(rd), .clr_flags(clr_flags),
    .dout(dout_a), .dout_valid(dv_a), .empty(empty_a), .full(full_a), .almost_full(af_a),
    .level(level_a), .overflow(ovf_a), .underflow(unf_a)
  );

  mic_pack_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .micData(micData), .wr(wr), .rd(rd), .clr_flags(clr_flags),
    .dout(dout_b), .dout_valid(dv_b), .empty(empty_b), .full(full_b), .almost_full(af_b),
    .level(level_b), .overflow(ovf_b), .underflow(unf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic exp_push(input logic [7:0] w);
    qa.push_back(w);
    qb.push_back(rev8(w));
  endtask

  // Bits go out w[7] first; optionally raise rd during the final bit.
  task automatic send_word(input logic [7:0] w, input bit pop_last);
    for (int i = 0; i < 8; i++) begin
      micData = w[7-i];
      wr      = 1'b1;
      rd      = pop_last && (i == 7);
      @(posedge clk);
      #1;
    end
    wr      = 1'b0;
    rd      = 1'b0;
    micData = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dv_a) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL msb_unexpected_word: got 0x%0h, expected no word", dout_a);
      end else begin
        ea = qa.pop_front();
        check("msb_word", {24'd0, dout_a}, {24'd0, ea});
      end
    end
    if (dv_b) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lsb_unexpected_word: got 0x%0h, expected no word", dout_b);
      end else begin
        eb = qb.pop_front();
        check("lsb_word", {24'd0, dout_b}, {24'd0, eb});
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", level_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_af", af_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_valid", dv_a, 0);
    check("rst_flags", {ovf_a, unf_a, ovf_b, unf_b}, 0);
    reset = 1'b0;

    // Bits 1,0,1,0,1,1,0,0: AC when MSB-first, 35 when LSB-first
    qa.push_back(8'hAC);
    qb.push_back(8'h35);
    send_word(8'hAC, 1'b0);
    @(negedge clk);
    check("first_level", level_a, 1);
    check("first_level_lsb", level_b, 1);
    pulse_rd();
    @(negedge clk);
    check("first_valid", dv_a, 1);
    check("first_empty", empty_a, 1);

    // Fill to full, watching almost_full and full
    for (int k = 0; k < 16; k++) begin
      exp_push(8'(8'h13 * k + 8'h05));
      send_word(8'(8'h13 * k + 8'h05), 1'b0);
      @(negedge clk);
      check("fill_level", level_a, k + 1);
      check("fill_af", af_a, (k + 1 >= 14) ? 1 : 0);
      check("fill_full", full_a, (k + 1 == 16) ? 1 : 0);
    end
    send_word(8'hEE, 1'b0);
    @(negedge clk);
    check("ovf_set", ovf_a, 1);
    check("ovf_set_lsb", ovf_b, 1);
    check("ovf_level", level_a, 16);
    check("ovf_no_unf", unf_a, 0);
    pulse_clr();
    @(negedge clk);
    check("ovf_clr", ovf_a, 0);

    // Push and pop together while full
    exp_push(8'h77);
    send_word(8'h77, 1'b1);
    @(negedge clk);
    check("simul_level", level_a, 16);
    check("simul_ovf", ovf_a, 0);
    check("simul_full", full_a, 1);

    // Drain everything
    rd = 1'b1;
    repeat (16) @(posedge clk);
    #1 rd = 1'b0;
    repeat (2) @(negedge clk);
    check("drain_empty", empty_a, 1);
    check("drain_level", level_a, 0);

    // Underflow, clear, and set-wins-over-clear
    pulse_rd();
    @(negedge clk);
    check("unf_set", unf_a, 1);
    check("unf_no_valid", dv_a, 0);
    check("unf_dout_hold", dout_a, 8'h77);
    check("unf_level", level_a, 0);
    pulse_clr();
    @(negedge clk);
    check("unf_clr", unf_a, 0);
    rd        = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    rd        = 1'b0;
    clr_flags = 1'b0;
    @(negedge clk);
    check("unf_set_wins", unf_a, 1);
    pulse_clr();
    @(negedge clk);
    check("unf_clr2", unf_b, 0);

    // Reset with stored words and a partial word discards both
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      micData = i[0];
      wr      = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    rd    = 1'b1;
    repeat (2) begin
      micData = ~micData;
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    micData = 1'b0;
    @(negedge clk);
    check("midrst_level", level_a, 0);
    check("midrst_empty", empty_b, 1);
    exp_push(8'h5A);
    send_word(8'h5A, 1'b0);
    @(negedge clk);
    check("midrst_one_word", level_a, 1);
    pulse_rd();
    @(negedge clk);
    check("midrst_drained", empty_a, 1);

    // 40 push/pop rounds wrap the pointers several times
    for (int k = 0; k < 40; k++) begin
      exp_push(8'(8'd37 * k + 8'd11));
      send_word(8'(8'd37 * k + 8'd11), 1'b0);
      pulse_rd();
    end
    repeat (3) @(negedge clk);
    check("wrap_level", level_a, 0);
    check("msb_queue_drained", qa.size(), 0);
    check("lsb_queue_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
